// File: rtl/pwm_carrier_gen.sv
// pwm_carrier_gen: up/down/up-down carrier for one PWM channel.
// Produces min/max strobes, a decimated shadow-update strobe and an irq pulse.
module pwm_carrier_gen #(
    parameter int PWMCOUNT_WIDTH = 16,
    parameter int DIVCLK_WIDTH   = 4,
    parameter int EVTCOUNT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      carr_onoff,
    input  logic [1:0]                count_mode,
    input  logic [1:0]                mask_mode,
    input  logic                      clkdiv_onoff,
    input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [PWMCOUNT_WIDTH-1:0] init_val,
    input  logic [EVTCOUNT_WIDTH-1:0] evt_num,
    input  logic                      int_onoff,
    output logic [PWMCOUNT_WIDTH-1:0] carrier,
    output logic                      carr_dir,
    output logic                      carr_min,
    output logic                      carr_max,
    output logic                      update,
    output logic                      irq
);

    localparam logic       CARR_ON      = 1'b1;
    localparam logic       CLKDIV_ON    = 1'b1;
    localparam logic       INT_ON       = 1'b1;
    localparam logic [1:0] COUNT_UP     = 2'b00;
    localparam logic [1:0] COUNT_DOWN   = 2'b01;
    localparam logic [1:0] COUNT_UPDOWN = 2'b10;

    typedef logic [PWMCOUNT_WIDTH-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    logic                      r_running;
    logic [DIVCLK_WIDTH-1:0]   r_presc;
    logic [EVTCOUNT_WIDTH-1:0] r_evt_cnt;
    cnt_t                      r_sh_period;
    logic [1:0]                r_sh_mode;
    cnt_t                      r_carrier;
    logic                      r_dir;
    logic                      r_min;
    logic                      r_max;
    logic                      r_update;
    logic                      r_irq;

    logic [1:0] w_mode_in;
    cnt_t       w_start_val;
    logic       w_tick;
    cnt_t       w_next;
    logic       w_next_dir;
    logic       w_min;
    logic       w_max;
    logic       w_evt;

    // Mode 2'b11 is folded into COUNT_UP before it reaches the shadow.
    assign w_mode_in   = (count_mode == 2'b11) ? COUNT_UP : count_mode;
    assign w_start_val = (init_val > period) ? period : init_val;
    assign w_tick      = (clkdiv_onoff == CLKDIV_ON) ? (r_presc == clkdiv) : 1'b1;

    always_comb begin
        w_next     = r_carrier;
        w_next_dir = r_dir;
        if (r_sh_period == '0) begin
            w_next = '0;
        end else begin
            case (r_sh_mode)
                COUNT_DOWN: begin
                    w_next = (r_carrier == '0) ? r_sh_period : r_carrier - ONE;
                end
                COUNT_UPDOWN: begin
                    if (r_dir) begin
                        if (r_carrier >= r_sh_period) begin
                            w_next     = r_sh_period - ONE;
                            w_next_dir = 1'b0;
                        end else begin
                            w_next = r_carrier + ONE;
                        end
                    end else begin
                        if (r_carrier == '0) begin
                            w_next     = ONE;
                            w_next_dir = 1'b1;
                        end else begin
                            w_next = r_carrier - ONE;
                        end
                    end
                end
                default: begin
                    w_next = (r_carrier >= r_sh_period) ? '0 : r_carrier + ONE;
                end
            endcase
        end
    end

    assign w_min = (w_next == '0);
    assign w_max = (w_next == r_sh_period);
    assign w_evt = (w_min && !mask_mode[0]) || (w_max && !mask_mode[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_running   <= 1'b0;
            r_presc     <= '0;
            r_evt_cnt   <= '0;
            r_sh_period <= '0;
            r_sh_mode   <= COUNT_UP;
            r_carrier   <= '0;
            r_dir       <= 1'b0;
            r_min       <= 1'b0;
            r_max       <= 1'b0;
            r_update    <= 1'b0;
            r_irq       <= 1'b0;
        end else if (carr_onoff != CARR_ON) begin
            r_running   <= 1'b0;
            r_presc     <= '0;
            r_evt_cnt   <= '0;
            r_sh_period <= period;
            r_sh_mode   <= w_mode_in;
            r_carrier   <= '0;
            r_dir       <= 1'b0;
            r_min       <= 1'b0;
            r_max       <= 1'b0;
            r_update    <= 1'b0;
            r_irq       <= 1'b0;
        end else if (!r_running) begin
            // Start edge still tracks the inputs, so a start straight
            // out of reset clamps against the live period.
            r_running   <= 1'b1;
            r_sh_period <= period;
            r_sh_mode   <= w_mode_in;
            r_carrier   <= w_start_val;
            r_dir       <= (w_mode_in != COUNT_DOWN);
            r_min       <= 1'b0;
            r_max       <= 1'b0;
            r_update    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_min    <= 1'b0;
            r_max    <= 1'b0;
            r_update <= 1'b0;
            r_irq    <= 1'b0;
            if (clkdiv_onoff == CLKDIV_ON) begin
                r_presc <= w_tick ? '0 : r_presc + DIVCLK_WIDTH'(1);
            end else begin
                r_presc <= '0;
            end
            if (w_tick) begin
                r_carrier <= w_next;
                r_dir     <= w_next_dir;
                r_min     <= w_min;
                r_max     <= w_max;
                if (w_evt) begin
                    if (r_evt_cnt == evt_num) begin
                        r_evt_cnt   <= '0;
                        r_update    <= 1'b1;
                        r_irq       <= (int_onoff == INT_ON);
                        r_sh_period <= period;
                        r_sh_mode   <= w_mode_in;
                        if (w_mode_in == COUNT_UP) begin
                            r_dir <= 1'b1;
                        end else if (w_mode_in == COUNT_DOWN) begin
                            r_dir <= 1'b0;
                        end
                    end else begin
                        r_evt_cnt <= r_evt_cnt + EVTCOUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign carrier  = r_carrier;
    assign carr_dir = r_dir;
    assign carr_min = r_min;
    assign carr_max = r_max;
    assign update   = r_update;
    assign irq      = r_irq;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Directed testbench for pwm_carrier_gen.
// Flags are compared as {carr_dir, carr_min, carr_max, update, irq}.
module tb_pwm_carrier_gen;

    localparam logic [1:0] M_UP     = 2'b00;
    localparam logic [1:0] M_DOWN   = 2'b01;
    localparam logic [1:0] M_UPDOWN = 2'b10;
    localparam logic [1:0] K_NONE   = 2'b00;
    localparam logic [1:0] K_MIN    = 2'b01;
    localparam logic [1:0] K_MAX    = 2'b10;
    localparam logic [1:0] K_BOTH   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        carr_onoff;
    logic [1:0]  count_mode;
    logic [1:0]  mask_mode;
    logic        clkdiv_onoff;
    logic [3:0]  clkdiv;
    logic [15:0] period;
    logic [15:0] init_val;
    logic [2:0]  evt_num;
    logic        int_onoff;
    logic [15:0] carrier;
    logic        carr_dir;
    logic        carr_min;
    logic        carr_max;
    logic        update;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_carrier_gen dut (
        .clk          (clk),
        .rst          (rst),
        .carr_onoff   (carr_onoff),
        .count_mode   (count_mode),
        .mask_mode    (mask_mode),
        .clkdiv_onoff (clkdiv_onoff),
        .clkdiv       (clkdiv),
        .period       (period),
        .init_val     (init_val),
        .evt_num      (evt_num),
        .int_onoff    (int_onoff),
        .carrier      (carrier),
        .carr_dir     (carr_dir),
        .carr_min     (carr_min),
        .carr_max     (carr_max),
        .update       (update),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle one cycle with the given setup, then turn on: returns at edge N.
    task automatic start_run(input logic [1:0] m, input logic [15:0] p,
                             input logic [15:0] iv, input logic dv_on,
                             input logic [3:0] d, input logic [1:0] k,
                             input logic [2:0] en, input logic io);
        rst          = 1'b0;
        carr_onoff   = 1'b0;
        count_mode   = m;
        period       = p;
        init_val     = iv;
        clkdiv_onoff = dv_on;
        clkdiv       = d;
        mask_mode    = k;
        evt_num      = en;
        int_onoff    = io;
        step();
        carr_onoff = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [4:0] f;
        rst        = 1'b1;
        carr_onoff = 1'b1;
        count_mode = M_UP;
        mask_mode  = K_NONE;
        clkdiv_onoff = 1'b0;
        clkdiv     = 4'd0;
        period     = 16'd4;
        init_val   = 16'd2;
        evt_num    = 3'd0;
        int_onoff  = 1'b1;
        step();
        step();
        f = {carr_dir, carr_min, carr_max, update, irq};
        n_cmp++;
        if (carrier !== 16'd0) begin
            $display("FAIL reset_carrier got %0d exp 0", carrier);
            n_fail++;
        end
        n_cmp++;
        if (f !== 5'b00000) begin
            $display("FAIL reset_flags got %b exp 00000", f);
            n_fail++;
        end
    endtask

    task automatic test_up();
        logic [4:0]  f;
        logic [4:0]  ef;
        logic [15:0] v;
        logic        mn;
        logic        mx;
        start_run(M_UP, 16'd4, 16'd0, 1'b0, 4'd0, K_NONE, 3'd0, 1'b1);
        f = {carr_dir, carr_min, carr_max, update, irq};
        n_cmp++;
        if (carrier !== 16'd0 || f !== 5'b10000) begin
            $display("FAIL up_start got %0d/%b exp 0/10000", carrier, f);
            n_fail++;
        end
        for (int e = 1; e <= 10; e++) begin
            step();
            v  = 16'(e % 5);
            mn = (v == 16'd0);
            mx = (v == 16'd4);
            ef = {1'b1, mn, mx, mn | mx, mn | mx};
            f  = {carr_dir, carr_min, carr_max, update, irq};
            n_cmp++;
            if (carrier !== v) begin
                $display("FAIL up_carrier e=%0d got %0d exp %0d", e, carrier, v);
                n_fail++;
            end
            n_cmp++;
            if (f !== ef) begin
                $display("FAIL up_flags e=%0d got %b exp %b", e, f, ef);
                n_fail++;
            end
        end
        carr_onoff = 1'b0;
        step();
        f = {carr_dir, carr_min, carr_max, update, irq};
        n_cmp++;
        if (carrier !== 16'd0 || f !== 5'b00000) begin
            $display("FAIL stop_idle got %0d/%b exp 0/00000", carrier, f);
            n_fail++;
        end
    endtask

    task automatic test_updown_div();
        int ec[15] = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
        int ed[15] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [4:0] f;
        logic [4:0] ef;
        logic       mn;
        logic       mx;
        start_run(M_UPDOWN, 16'd3, 16'd0, 1'b1, 4'd1, K_NONE, 3'd0, 1'b0);
        n_cmp++;
        if (carrier !== 16'd0 || carr_dir !== 1'b1) begin
            $display("FAIL ud_start got %0d/%b exp 0/1", carrier, carr_dir);
            n_fail++;
        end
        for (int e = 1; e <= 15; e++) begin
            step();
            mn = (e == 12);
            mx = (e == 6);
            ef = {ed[e-1] != 0, mn, mx, mn | mx, 1'b0};
            f  = {carr_dir, carr_min, carr_max, update, irq};
            n_cmp++;
            if (carrier !== 16'(ec[e-1])) begin
                $display("FAIL ud_carrier e=%0d got %0d exp %0d", e, carrier, ec[e-1]);
                n_fail++;
            end
            n_cmp++;
            if (f !== ef) begin
                $display("FAIL ud_flags e=%0d got %b exp %b", e, f, ef);
                n_fail++;
            end
        end
    endtask

    task automatic test_down_decim();
        logic [4:0]  f;
        logic [4:0]  ef;
        logic [15:0] v;
        logic        u;
        start_run(M_DOWN, 16'd5, 16'd0, 1'b0, 4'd0, K_MIN, 3'd2, 1'b1);
        n_cmp++;
        if (carrier !== 16'd0 || carr_dir !== 1'b0) begin
            $display("FAIL dn_start got %0d/%b exp 0/0", carrier, carr_dir);
            n_fail++;
        end
        for (int e = 1; e <= 19; e++) begin
            step();
            v  = 16'(5 - ((e - 1) % 6));
            u  = (e == 13);
            ef = {1'b0, v == 16'd0, v == 16'd5, u, u};
            f  = {carr_dir, carr_min, carr_max, update, irq};
            n_cmp++;
            if (carrier !== v) begin
                $display("FAIL dn_carrier e=%0d got %0d exp %0d", e, carrier, v);
                n_fail++;
            end
            n_cmp++;
            if (f !== ef) begin
                $display("FAIL dn_flags e=%0d got %b exp %b", e, f, ef);
                n_fail++;
            end
        end
    endtask

    task automatic test_shadow_shrink();
        int ec[16] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic [4:0] f;
        logic [4:0] ef;
        logic       mn;
        logic       mx;
        start_run(M_UP, 16'd7, 16'd0, 1'b0, 4'd0, K_MAX, 3'd0, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            step();
            mn = (ec[e-1] == 0);
            mx = (e == 7 || e == 11 || e == 15);
            ef = {1'b1, mn, mx, mn, 1'b0};
            f  = {carr_dir, carr_min, carr_max, update, irq};
            n_cmp++;
            if (carrier !== 16'(ec[e-1])) begin
                $display("FAIL sh_carrier e=%0d got %0d exp %0d", e, carrier, ec[e-1]);
                n_fail++;
            end
            n_cmp++;
            if (f !== ef) begin
                $display("FAIL sh_flags e=%0d got %b exp %b", e, f, ef);
                n_fail++;
            end
            if (e == 5) period = 16'd3;
        end
    endtask

    task automatic test_minmax_mask();
        logic [4:0]  f;
        logic [4:0]  ef;
        logic [15:0] v;
        start_run(M_UP, 16'd3, 16'd9, 1'b0, 4'd0, K_BOTH, 3'd0, 1'b1);
        n_cmp++;
        if (carrier !== 16'd3 || {carr_min, carr_max} !== 2'b00) begin
            $display("FAIL mm_start_clamp got %0d/%b%b exp 3/00", carrier, carr_min, carr_max);
            n_fail++;
        end
        for (int e = 1; e <= 10; e++) begin
            step();
            v  = 16'((3 + e) % 4);
            ef = {1'b1, v == 16'd0, v == 16'd3, 1'b0, 1'b0};
            f  = {carr_dir, carr_min, carr_max, update, irq};
            n_cmp++;
            if (carrier !== v) begin
                $display("FAIL mm_carrier e=%0d got %0d exp %0d", e, carrier, v);
                n_fail++;
            end
            n_cmp++;
            if (f !== ef) begin
                $display("FAIL mm_flags e=%0d got %b exp %b", e, f, ef);
                n_fail++;
            end
            if (e == 1) period = 16'd6;
        end
    endtask

    task automatic test_reset_restart();
        logic [4:0] f;
        start_run(M_UP, 16'd12, 16'd5, 1'b0, 4'd0, K_NONE, 3'd0, 1'b1);
        for (int e = 1; e <= 4; e++) step();
        n_cmp++;
        if (carrier !== 16'd9) begin
            $display("FAIL rr_pre got %0d exp 9", carrier);
            n_fail++;
        end
        rst = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            step();
            f = {carr_dir, carr_min, carr_max, update, irq};
            n_cmp++;
            if (carrier !== 16'd0 || f !== 5'b00000) begin
                $display("FAIL rr_in_reset e=%0d got %0d/%b exp 0/00000", e, carrier, f);
                n_fail++;
            end
        end
        rst = 1'b0;
        step();
        f = {carr_dir, carr_min, carr_max, update, irq};
        n_cmp++;
        if (carrier !== 16'd5 || f !== 5'b10000) begin
            $display("FAIL rr_restart got %0d/%b exp 5/10000", carrier, f);
            n_fail++;
        end
        step();
        n_cmp++;
        if (carrier !== 16'd6) begin
            $display("FAIL rr_next got %0d exp 6", carrier);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_updown_div();
        test_down_decim();
        test_shadow_shrink();
        test_minmax_mask();
        test_reset_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_carrier_gen.md
# pwm_carrier_gen

Carrier generator for one channel of the 8-channel PWM core. It produces the triangle or sawtooth carrier count consumed by the downstream compare/dead-time stage. It also produces min/max event strobes and a shadow-update strobe that the compare stage uses to reload its duty registers. Event masking and decimation generate a per-channel interrupt pulse.

## Interface
- `PWMCOUNT_WIDTH`, default 16: carrier counter and period width.
- `DIVCLK_WIDTH`, default 4: clock-divider value width.
- `EVTCOUNT_WIDTH`, default 3: event-decimation counter width.
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `carr_onoff`  in  1  `_carr_onoff`: CARR_ON runs the carrier.
- `count_mode`  in  2  `_count_mode`: shadowed. The value 2'b11 is treated as COUNT_UP.
- `mask_mode`  in  2  `_mask_mode`: selects which events are masked.
- `clkdiv_onoff`  in  1  `_clkdiv_onoff`.
- `clkdiv`  in  DIVCLK_WIDTH  divide value D. The counter steps every D+1 clocks.
- `period`  in  PWMCOUNT_WIDTH  carrier period P. Shadowed.
- `init_val`  in  PWMCOUNT_WIDTH  counter start value.
- `evt_num`  in  EVTCOUNT_WIDTH  event decimation. The update strobe fires every evt_num+1 unmasked events.
- `int_onoff`  in  1  `_int_onoff`.
- `carrier`  out  PWMCOUNT_WIDTH  carrier count.
- `carr_dir`  out  1  count direction: 1 = up, 0 = down.
- `carr_min`  out  1  one-cycle strobe. Asserted when the carrier takes the value 0.
- `carr_max`  out  1  one-cycle strobe. Asserted when the carrier takes the value P.
- `update`  out  1  one-cycle shadow-load strobe, for this block and downstream.
- `irq`  out  1  one-cycle interrupt pulse.

## Operation
**Reset.** All outputs are 0. Internal state at reset:
- `carr_dir` = 0; internal `running` = 0.
- Shadow period = 0; shadow mode = COUNT_UP.
- Prescaler and event counter = 0.

**Idle** (carr_onoff = CARR_OFF):
- Outputs are held at their reset values.
- Prescaler and event counter are cleared.
- Shadow registers load `period` and `count_mode` every cycle.

**Start.** In the first cycle `carr_onoff` is sampled ON while `running` = 0:
- `carrier` loads min(init_val, shadow P).
- Direction is set: down for COUNT_DOWN, up otherwise.
- `running` is set to 1.
- No events are generated in this cycle.

**Tick.** A tick is asserted every cycle when CLKDIV_OFF. When CLKDIV_ON, a prescaler counts 0..D and the tick is asserted when prescaler == D, after which the prescaler clears. D = 0 gives a tick every cycle.

**Counter.** The counter changes only on a tick:
- UP: if carrier ≥ P, the next value is 0; otherwise carrier + 1.
- DOWN: if carrier = 0, the next value is P; otherwise carrier − 1.
- UPDOWN, going up: if carrier ≥ P, the next value is P − 1 and direction becomes down; otherwise carrier + 1.
- UPDOWN, going down: if carrier = 0, the next value is 1 and direction becomes up; otherwise carrier − 1.
- P = 0 in any mode: the carrier stays at 0.

**Event strobes.** On a tick, `carr_min` = (next value == 0) and `carr_max` = (next value == P). Both are registered with `carrier`, so each strobe is high for exactly one clock in the first cycle of the new value.
- With P = 0, both strobes fire on every tick.

**Masking.**
- NO_MASK: both min and max events count.
- MIN_MASK: only max events count.
- MAX_MASK: only min events count.
- MINMAX_MASK: no events count, so `update` and `irq` are never asserted while running.
- Simultaneous min and max count as one event.

**Decimation.** On an unmasked event:
- If evt_cnt == evt_num: evt_cnt clears, `update` = 1, and `irq` = (int_onoff == INT_ON).
- Otherwise evt_cnt increments.

**Shadow load.** Shadow period and mode load on the same edge that asserts `update`. The new P and mode apply from the next tick.
- A mode change to UP sets direction up.
- A mode change to DOWN sets direction down.
- A mode change to UPDOWN keeps the current direction.
- If the new P is below the current carrier: UP wraps to 0 on the next tick; DOWN and UPDOWN-down decrement toward 0.

**Stop.** `carr_onoff` going OFF mid-period returns the block to idle on the next edge. There is no completion of the current period.

**Reset priority.** `rst` overrides all other inputs in every cycle.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Start: `carrier` = init_val at edge N, the first edge where `carr_onoff` is sampled ON.
- First tick with divider D: edge N + D + 1.
- UP period = (P + 1)·(D + 1) clocks.
- UPDOWN period = 2P·(D + 1) clocks.
- `update`, `irq`, and the min/max strobe are coincident, in the same cycle.
- Divider changes take effect immediately, with no shadowing. A prescaler value above the new D completes a wrap at 2^DIVCLK_WIDTH − 1 before reaching 0.

## Test plan
1. UP, P=4, clkdiv OFF, init 0:
   - `carrier` sequence 0,1,2,3,4,0,…
   - `carr_max` on every value 4; `carr_min` on every value 0 after the first.
   - With NO_MASK and evt_num=0, `update` fires with each strobe.
2. UPDOWN, P=3, CLKDIV_ON, D=1:
   - Each value is held for 2 clocks: 0,1,2,3,2,1,0,…
   - `carr_dir` toggles at 3 and at 0; strobes last 1 clock only.
3. DOWN, P=5, MIN_MASK, evt_num=2, INT_ON: `irq` and `update` fire on every 3rd value-5 entry only.
4. UP, P=7, MAX_MASK, evt_num=0:
   - `period` changed to 3 while the carrier is at 5.
   - The carrier continues 6,7,0; `update` is asserted with the 0.
   - After that, 0..3 repeats.
5. MINMAX_MASK with `period` changed mid-run: `update` and `irq` are never asserted, and the old P stays active.
6. `rst` asserted while running at carrier=9, then deasserted with CARR_ON held:
   - All outputs are 0 during reset.
   - The restart loads init_val on the first edge after reset.
